// File: rtl/unit_propagation_engine_pkg.sv
// Shared types and default constants for the unit-propagation engine.
// Optional feature macro used by the top: UPE_DEDUP_EN.
package sat_pkg;

    localparam int unsigned DEF_VAR_PER_CLAUSE = 5;
    localparam int unsigned DEF_NUM_VARIABLE   = 128;
    localparam int unsigned DEF_NUM_CLAUSE     = 1023;
    localparam int unsigned DEF_IMP_FIFO_DEPTH = 8;
    localparam int unsigned DEF_VARIABLE_INDEX = $clog2(DEF_NUM_VARIABLE);
    localparam int unsigned DEF_CLAUSE_INDEX   = $clog2(DEF_NUM_CLAUSE);

    typedef enum logic [1:0] {
        CS_SAT        = 2'd0,
        CS_UNIT       = 2'd1,
        CS_CONFLICT   = 2'd2,
        CS_UNRESOLVED = 2'd3
    } clause_status_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EVAL = 2'd2,
        ST_DONE = 2'd3
    } upe_state_t;

    typedef struct packed {
        logic [DEF_VARIABLE_INDEX-1:0] variable;
        logic                          value;
        logic [DEF_CLAUSE_INDEX-1:0]   clause;
    } implication_t;

endpackage

// File: rtl/unit_propagation_engine_clause_status_eval.sv
// Combinational classifier: one clause against the current assignment.
module clause_status_eval
    import sat_pkg::*;
#(
    parameter int unsigned VAR_PER_CLAUSE = DEF_VAR_PER_CLAUSE,
    parameter int unsigned NUM_VARIABLE   = DEF_NUM_VARIABLE,
    parameter int unsigned VARIABLE_INDEX = $clog2(NUM_VARIABLE)
) (
    input  logic [VAR_PER_CLAUSE-1:0]                i_mask,
    input  logic [VAR_PER_CLAUSE*VARIABLE_INDEX-1:0] i_variable,
    input  logic [VAR_PER_CLAUSE-1:0]                i_pole,
    input  logic [NUM_VARIABLE-1:0]                  i_assign_valid,
    input  logic [NUM_VARIABLE-1:0]                  i_assign_value,
    output clause_status_t                           o_status,
    output logic [VARIABLE_INDEX-1:0]                o_imp_variable,
    output logic                                     o_imp_value
);

    logic                      w_sat;
    logic                      w_free_seen;
    logic                      w_free_multi;
    logic [VARIABLE_INDEX-1:0] w_v;

    // Scan slots: any satisfied literal, and how many free literals (0, 1, many)
    always_comb begin
        w_sat          = 1'b0;
        w_free_seen    = 1'b0;
        w_free_multi   = 1'b0;
        w_v            = '0;
        o_imp_variable = '0;
        o_imp_value    = 1'b0;
        for (int unsigned i = 0; i < VAR_PER_CLAUSE; i++) begin
            w_v = i_variable[i*VARIABLE_INDEX +: VARIABLE_INDEX];
            if (i_mask[i]) begin
                if (i_assign_valid[w_v]) begin
                    if (i_assign_value[w_v] == i_pole[i]) w_sat = 1'b1;
                end else begin
                    if (w_free_seen) w_free_multi = 1'b1;
                    w_free_seen    = 1'b1;
                    o_imp_variable = w_v;
                    o_imp_value    = i_pole[i];
                end
            end
        end
        if (w_sat)             o_status = CS_SAT;
        else if (!w_free_seen) o_status = CS_CONFLICT;
        else if (!w_free_multi) o_status = CS_UNIT;
        else                   o_status = CS_UNRESOLVED;
    end

endmodule

// File: rtl/unit_propagation_engine.sv
// Unit-propagation engine: sequences clause reads, classifies each clause,
// buffers implications in a FIFO and stops on the first conflict.
// Optional UPE_DEDUP_EN: suppress duplicate implications within a pass and
// turn contradicting implications into conflicts.
module unit_propagation_engine
    import sat_pkg::*;
#(
    parameter int unsigned VAR_PER_CLAUSE = DEF_VAR_PER_CLAUSE,
    parameter int unsigned NUM_VARIABLE   = DEF_NUM_VARIABLE,
    parameter int unsigned NUM_CLAUSE     = DEF_NUM_CLAUSE,
    parameter int unsigned VARIABLE_INDEX = $clog2(NUM_VARIABLE),
    parameter int unsigned CLAUSE_INDEX   = $clog2(NUM_CLAUSE),
    parameter int unsigned IMP_FIFO_DEPTH = DEF_IMP_FIFO_DEPTH
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic                                     start,
    input  logic [CLAUSE_INDEX:0]                    clause_count,
    input  logic [NUM_VARIABLE-1:0]                  assign_valid,
    input  logic [NUM_VARIABLE-1:0]                  assign_value,
    output logic                                     mem_rd_en,
    output logic [CLAUSE_INDEX-1:0]                  mem_addr,
    input  logic [VAR_PER_CLAUSE-1:0]                mem_mask,
    input  logic [VAR_PER_CLAUSE*VARIABLE_INDEX-1:0] mem_variable,
    input  logic [VAR_PER_CLAUSE-1:0]                mem_pole,
    output logic                                     imp_valid,
    input  logic                                     imp_ready,
    output logic [VARIABLE_INDEX-1:0]                imp_variable,
    output logic                                     imp_value,
    output logic [CLAUSE_INDEX-1:0]                  imp_clause,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     conflict,
    output logic [CLAUSE_INDEX-1:0]                  conflict_clause
);

    localparam int unsigned PTR_W = $clog2(IMP_FIFO_DEPTH);

    upe_state_t                r_state;
    logic [CLAUSE_INDEX-1:0]   r_index;
    logic [CLAUSE_INDEX:0]     r_count;
    logic                      r_conflict;
    logic [CLAUSE_INDEX-1:0]   r_conflict_clause;

    logic [VARIABLE_INDEX-1:0] r_fifo_var [IMP_FIFO_DEPTH];
    logic                      r_fifo_val [IMP_FIFO_DEPTH];
    logic [CLAUSE_INDEX-1:0]   r_fifo_cl  [IMP_FIFO_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [PTR_W:0]            r_occ;

    clause_status_t            w_status;
    logic [VARIABLE_INDEX-1:0] w_imp_var;
    logic                      w_imp_val;
    logic                      w_dup;
    logic                      w_contra;
    logic                      w_eval;
    logic                      w_unit;
    logic                      w_conf;
    logic                      w_full;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_advance;
    logic                      w_last;
    logic                      w_start;

    clause_status_eval #(
        .VAR_PER_CLAUSE (VAR_PER_CLAUSE),
        .NUM_VARIABLE   (NUM_VARIABLE),
        .VARIABLE_INDEX (VARIABLE_INDEX)
    ) u_eval (
        .i_mask         (mem_mask),
        .i_variable     (mem_variable),
        .i_pole         (mem_pole),
        .i_assign_valid (assign_valid),
        .i_assign_value (assign_value),
        .o_status       (w_status),
        .o_imp_variable (w_imp_var),
        .o_imp_value    (w_imp_val)
    );

    assign w_start = (r_state == ST_IDLE) && start;

`ifdef UPE_DEDUP_EN
    logic [NUM_VARIABLE-1:0] r_pend;
    logic [NUM_VARIABLE-1:0] r_pval;

    assign w_dup    = r_pend[w_imp_var] && (r_pval[w_imp_var] == w_imp_val);
    assign w_contra = r_pend[w_imp_var] && (r_pval[w_imp_var] != w_imp_val);

    // Track implications already queued during the current pass
    always_ff @(posedge clock) begin
        if (!reset_n || w_start) begin
            r_pend <= '0;
            r_pval <= '0;
        end else if (w_push) begin
            r_pend[w_imp_var] <= 1'b1;
            r_pval[w_imp_var] <= w_imp_val;
        end
    end
`else
    assign w_dup    = 1'b0;
    assign w_contra = 1'b0;
`endif

    assign w_eval    = (r_state == ST_EVAL);
    assign w_unit    = (w_status == CS_UNIT) && !w_dup && !w_contra;
    assign w_conf    = (w_status == CS_CONFLICT) || ((w_status == CS_UNIT) && w_contra);
    assign w_full    = (r_occ == (PTR_W+1)'(IMP_FIFO_DEPTH));
    assign w_push    = w_eval && w_unit && !w_full;
    assign w_pop     = (r_occ != '0) && imp_ready;
    // A unit clause facing a full FIFO holds in EVAL; the memory keeps its data.
    assign w_advance = w_eval && !w_conf && !(w_unit && w_full);
    assign w_last    = (({1'b0, r_index} + (CLAUSE_INDEX+1)'(1)) == r_count);

    // Pass sequencer: IDLE -> READ/EVAL per clause -> DONE
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state           <= ST_IDLE;
            r_index           <= '0;
            r_count           <= '0;
            r_conflict        <= 1'b0;
            r_conflict_clause <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_count           <= clause_count;
                        r_index           <= '0;
                        r_conflict        <= 1'b0;
                        r_conflict_clause <= '0;
                        r_state           <= (clause_count == '0) ? ST_DONE : ST_READ;
                    end
                end
                ST_READ: r_state <= ST_EVAL;
                ST_EVAL: begin
                    if (w_conf) begin
                        r_conflict        <= 1'b1;
                        r_conflict_clause <= r_index;
                        r_state           <= ST_DONE;
                    end else if (w_advance) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_index <= r_index + CLAUSE_INDEX'(1);
                            r_state <= ST_READ;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Implication FIFO pointers and occupancy
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + (PTR_W+1)'(1);
                2'b01:   r_occ <= r_occ - (PTR_W+1)'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Implication FIFO storage
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_var[r_wr_ptr] <= w_imp_var;
            r_fifo_val[r_wr_ptr] <= w_imp_val;
            r_fifo_cl[r_wr_ptr]  <= r_index;
        end
    end

    assign mem_rd_en       = (r_state == ST_READ);
    assign mem_addr        = r_index;
    assign busy            = (r_state != ST_IDLE);
    assign done            = (r_state == ST_DONE);
    assign conflict        = r_conflict;
    assign conflict_clause = r_conflict_clause;
    assign imp_valid       = (r_occ != '0);
    assign imp_variable    = imp_valid ? r_fifo_var[r_rd_ptr] : '0;
    assign imp_value       = imp_valid ? r_fifo_val[r_rd_ptr] : 1'b0;
    assign imp_clause      = imp_valid ? r_fifo_cl[r_rd_ptr]  : '0;

endmodule

// File: doc/unit_propagation_engine.md
# unit_propagation_engine

Sequential unit-propagation (BCP) engine for the SAT solver datapath. On `start` it walks the clause memory from index 0 to `clause_count-1` and classifies every clause against the current variable assignment as SAT, UNIT, CONFLICT or UNRESOLVED. Each UNIT clause yields an implied literal, pushed into an internal FIFO drained by the decision/trail logic over a valid/ready stream. The pass stops early on the first conflict. It generalises the combinational partial-SAT and unit-clause evaluators to arbitrary clause width, adds clause sequencing and implication buffering, and adds conflict detection.

## Interface
Parameters:
- `VAR_PER_CLAUSE`, 5, literal slots per clause
- `NUM_VARIABLE`, 128, number of variables
- `NUM_CLAUSE`, 1023, clause memory depth
- `VARIABLE_INDEX`, $clog2(NUM_VARIABLE), variable index width
- `CLAUSE_INDEX`, $clog2(NUM_CLAUSE), clause index width
- `IMP_FIFO_DEPTH`, 8, implication FIFO entries (power of two, ≥2)

Ports:
- `clock` in 1: single clock, all logic on posedge
- `reset_n` in 1: synchronous, active-low reset
- `start` in 1: begin a pass (single-cycle pulse)
- `clause_count` in CLAUSE_INDEX+1: clauses in this pass, sampled on `start`
- `assign_valid` in NUM_VARIABLE: 1 = variable assigned
- `assign_value` in NUM_VARIABLE: assigned value
- `mem_rd_en` out 1: clause memory read strobe
- `mem_addr` out CLAUSE_INDEX: clause index to read
- `mem_mask` in VAR_PER_CLAUSE: literal slot used
- `mem_variable` in VAR_PER_CLAUSE×VARIABLE_INDEX: variable per slot
- `mem_pole` in VAR_PER_CLAUSE: 1 = positive literal, 0 = negated
- `imp_valid` out 1: FIFO head valid
- `imp_ready` in 1: consumer accepts head
- `imp_variable` out VARIABLE_INDEX: implied variable
- `imp_value` out 1: implied value
- `imp_clause` out CLAUSE_INDEX: reason clause
- `busy` out 1: pass in progress
- `done` out 1: one-cycle pulse at pass end (with or without conflict)
- `conflict` out 1: last pass ended in conflict (held until next accepted `start`)
- `conflict_clause` out CLAUSE_INDEX: clause that conflicted (valid while `conflict`)

## Operation
- Literal slot i is active if `mem_mask[i]`. It is satisfied if active, assigned, and `assign_value[var]==mem_pole[i]`. It is free if active and unassigned.
- Clause status is chosen in this order:
  - any satisfied slot → SAT
  - exactly one free slot → UNIT; the implication is (that variable, its pole)
  - zero free slots → CONFLICT (an all-masked clause is a CONFLICT)
  - otherwise → UNRESOLVED
- FSM states: IDLE, READ, EVAL, DONE.
  - IDLE: `start` latches `clause_count` and clears `conflict`. Go to READ, or to DONE if count is 0.
  - READ: assert `mem_rd_en` with `mem_addr`=current index → EVAL.
  - EVAL: memory data is valid; classify the clause.
    - UNIT with FIFO full: stay in EVAL (memory holds its output until the next `mem_rd_en`).
    - UNIT with FIFO not full: push the implication.
    - CONFLICT: set `conflict` and `conflict_clause` → DONE.
    - Otherwise: if index==count-1 → DONE, else increment index → READ.
  - DONE: pulse `done` → IDLE.
- `start` outside IDLE is ignored.
- `assign_valid`/`assign_value` must be stable while `busy`. Implications are not fed back within a pass.
- The FIFO is independent of the FSM:
  - pop when `imp_valid && imp_ready`
  - push and pop in the same cycle is legal whenever not full
  - entries remaining after `done` are still drained normally
  - the next `start` does not flush the FIFO

## Timing
- Reset (`reset_n`=0 at posedge) forces:
  - FSM to IDLE, index to 0
  - `busy`=0, `done`=0, `conflict`=0, `conflict_clause`=0, `mem_rd_en`=0, `mem_addr`=0
  - FIFO emptied, `imp_valid`=0, `imp_*` data=0
- Reset mid-pass aborts the pass without a `done` pulse.
- Clause memory read latency is 1 cycle: `mem_rd_en` in cycle t → data valid in cycle t+1.
- Pass timing, with `start` sampled at cycle 0:
  - `busy`=1 from cycle 1.
  - Clause k is read in cycle 1+2k and evaluated in cycle 2+2k, plus any full-FIFO stall cycles.
  - With no stalls and no conflict, `done`=1 in cycle 2N+1, then `busy`=0 next cycle.
  - `clause_count`=0 → `done` in cycle 1.
- Push in cycle t → `imp_valid`=1 in cycle t+1. Full is computed from the registered occupancy.

## Configuration
- `UPE_DEDUP_EN` defined:
  - Adds an NUM_VARIABLE-bit pending bitmap plus a value bitmap, both cleared on `start`.
  - A UNIT clause whose variable is already pending with the same value is dropped: no push, no stall.
  - Pending with the opposite value is treated as CONFLICT for that clause.
- Undefined: every UNIT clause is pushed, duplicates and contradictions included. The consumer resolves them.

## Structure
- `sat_pkg` holds:
  - `clause_status_t` enum (SAT, UNIT, CONFLICT, UNRESOLVED)
  - `implication_t` struct (variable, value, clause)
  - FSM state enum
  - default parameter constants
- Sub-module `clause_status_eval`: combinational, parametrised by VAR_PER_CLAUSE. Produces status, implied variable and implied value. The FSM and FIFO live in the top.

## Test plan
- Clause 0: mask 00011, vars {3,7}, poles {1,0}; var 3 assigned 0, var 7 free; count=1 → one implication (7,0,clause 0); `done` at cycle 3; `conflict`=0.
- Clause 1 all slots assigned false, count=4 → `conflict`=1, `conflict_clause`=1, `done` at cycle 5; clauses 2–3 never read.
- 10 UNIT clauses, `imp_ready`=0 → 8 pushes, then EVAL stalls. Raise `imp_ready` → all 10 delivered in clause order; `done` after last push.
- `clause_count`=0 → `done` at cycle 1, no `mem_rd_en`. A `start` while `busy` is ignored.
- `reset_n`=0 in the middle of clause 5 of 10 → all outputs return to reset values next cycle; no `done`; FIFO empty.
- With `UPE_DEDUP_EN`: clauses imply (9,1), (9,1), (9,0) → a single push of (9,1), then conflict on clause 2.
